// File: rtl/data_memory_ctrl_if.sv
// Request/response bus for the data memory controller.
// The master issues one request at a time; the slave answers with a one-cycle strobe.
interface data_memory_ctrl_if;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [31:0] address_in;
    logic [31:0] write_data_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [5:0]  opcode_in;
    logic        resp_valid_out;
    logic [31:0] read_data_out;
    logic        error_out;

    modport master (
        output req_valid_in, address_in, write_data_in, mem_read_in, mem_write_in, opcode_in,
        input  req_ready_out, resp_valid_out, read_data_out, error_out
    );

    modport slave (
        input  req_valid_in, address_in, write_data_in, mem_read_in, mem_write_in, opcode_in,
        output req_ready_out, resp_valid_out, read_data_out, error_out
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with byte/halfword/word loads and stores, a
// power-up clear sequence, configurable load latency and a registered debug read port.
module data_memory_ctrl #(
    parameter int DEPTH        = 256,
    parameter int LOAD_LATENCY = 1,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    data_memory_ctrl_if.slave   bus,
    input  logic [AW-1:0]       debug_addr_in,
    output logic [31:0]         debug_data_out
);

    localparam logic [5:0] OPCODE_LB  = 6'h00;
    localparam logic [5:0] OPCODE_LH  = 6'h01;
    localparam logic [5:0] OPCODE_LW  = 6'h02;
    localparam logic [5:0] OPCODE_LBU = 6'h04;
    localparam logic [5:0] OPCODE_LHU = 6'h05;
    localparam logic [5:0] OPCODE_LWU = 6'h06;
    localparam logic [5:0] OPCODE_SB  = 6'h08;
    localparam logic [5:0] OPCODE_SH  = 6'h09;
    localparam logic [5:0] OPCODE_SW  = 6'h0A;

    typedef enum logic [1:0] {CLEAR, IDLE, LOAD_WAIT, RESP} state_t;

    state_t        state_q;
    logic [AW-1:0] clr_idx_q;
    logic [1:0]    wait_cnt_q;
    logic          ready_q;
    logic          resp_valid_q;
    logic          error_q;
    logic [31:0]   read_data_q;
    logic [31:0]   pend_data_q;

    logic [31:0]   mem [DEPTH];

    logic          is_load, is_store, ld_signed, acc_half, acc_word;
    logic          misalign, out_of_range, dir_err, req_err;
    logic          accept, st_we, ld_go;
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word, ld_data, st_data;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [3:0]    st_be;

    assign bus.req_ready_out  = ready_q;
    assign bus.resp_valid_out = resp_valid_q;
    assign bus.error_out      = error_q;
    assign bus.read_data_out  = read_data_q;

    assign word_idx = bus.address_in[AW+1:2];
    assign lane     = bus.address_in[1:0];

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        ld_signed = 1'b0;
        acc_half  = 1'b0;
        acc_word  = 1'b0;
        case (bus.opcode_in)
            OPCODE_LB:  begin is_load = 1'b1; ld_signed = 1'b1; end
            OPCODE_LBU: is_load = 1'b1;
            OPCODE_LH:  begin is_load = 1'b1; ld_signed = 1'b1; acc_half = 1'b1; end
            OPCODE_LHU: begin is_load = 1'b1; acc_half = 1'b1; end
            OPCODE_LW:  begin is_load = 1'b1; acc_word = 1'b1; end
            OPCODE_LWU: begin is_load = 1'b1; acc_word = 1'b1; end
            OPCODE_SB:  is_store = 1'b1;
            OPCODE_SH:  begin is_store = 1'b1; acc_half = 1'b1; end
            OPCODE_SW:  begin is_store = 1'b1; acc_word = 1'b1; end
            default:    ;
        endcase
    end

    // Direction/opcode mismatch is an error only when a transfer is actually requested.
    assign misalign     = (acc_half & lane[0]) | (acc_word & (|lane));
    assign out_of_range = |bus.address_in[31:AW+2];
    assign dir_err      = (bus.mem_read_in & bus.mem_write_in)
                        | (bus.mem_read_in & ~is_load)
                        | (bus.mem_write_in & ~is_store);
    assign req_err      = (bus.mem_read_in | bus.mem_write_in) & (dir_err | misalign | out_of_range);

    assign accept = ready_q & bus.req_valid_in;
    assign st_we  = accept & bus.mem_write_in & ~req_err;
    assign ld_go  = accept & bus.mem_read_in & ~req_err;

    assign rd_word  = mem[word_idx];
    assign byte_sel = rd_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = '0;
        if (acc_word)
            ld_data = rd_word;
        else if (acc_half)
            ld_data = {{16{ld_signed & half_sel[15]}}, half_sel};
        else
            ld_data = {{24{ld_signed & byte_sel[7]}}, byte_sel};
    end

    always_comb begin
        st_be   = '0;
        st_data = '0;
        if (acc_word) begin
            st_be   = 4'hF;
            st_data = bus.write_data_in;
        end else if (acc_half) begin
            st_be   = lane[1] ? 4'hC : 4'h3;
            st_data = {2{bus.write_data_in[15:0]}};
        end else begin
            st_be   = 4'b0001 << lane;
            st_data = {4{bus.write_data_in[7:0]}};
        end
    end

    // No reset on the array: the CLEAR sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_idx_q] <= '0;
        end else if (st_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (st_be[i])
                    mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            debug_data_out <= '0;
        else
            debug_data_out <= mem[debug_addr_in];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= CLEAR;
            clr_idx_q    <= '0;
            wait_cnt_q   <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            error_q      <= 1'b0;
            read_data_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + AW'(1);
                    if (clr_idx_q == AW'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.req_valid_in) begin
                        ready_q <= 1'b0;
                        if (ld_go && LOAD_LATENCY > 1) begin
                            state_q     <= LOAD_WAIT;
                            pend_data_q <= ld_data;
                            wait_cnt_q  <= 2'(LOAD_LATENCY - 2);
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            error_q      <= req_err;
                            read_data_q  <= ld_go ? ld_data : '0;
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        error_q      <= 1'b0;
                        read_data_q  <= pend_data_q;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed vector table, reset/latency
// sequences and randomized requests against a byte-level reference model.
module tb_data_memory_ctrl;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;
    localparam int AW    = 8;

    localparam logic [5:0] OPCODE_LB  = 6'h00;
    localparam logic [5:0] OPCODE_LH  = 6'h01;
    localparam logic [5:0] OPCODE_LW  = 6'h02;
    localparam logic [5:0] OPCODE_LBU = 6'h04;
    localparam logic [5:0] OPCODE_LHU = 6'h05;
    localparam logic [5:0] OPCODE_LWU = 6'h06;
    localparam logic [5:0] OPCODE_SB  = 6'h08;
    localparam logic [5:0] OPCODE_SH  = 6'h09;
    localparam logic [5:0] OPCODE_SW  = 6'h0A;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [AW-1:0] debug_addr;
    logic [31:0]   debug_data;

    always #5 clk = ~clk;

    data_memory_ctrl_if bus();

    data_memory_ctrl #(.DEPTH(DEPTH), .LOAD_LATENCY(LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .debug_addr_in  (debug_addr),
        .debug_data_out (debug_data)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic [5:0]  op;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void op_info(input logic [5:0] op, output logic ld, output logic st,
                                    output logic sgn, output int unsigned size);
        ld = 1'b0; st = 1'b0; sgn = 1'b0; size = 4;
        case (op)
            OPCODE_LB:  begin ld = 1'b1; sgn = 1'b1; size = 1; end
            OPCODE_LBU: begin ld = 1'b1; size = 1; end
            OPCODE_LH:  begin ld = 1'b1; sgn = 1'b1; size = 2; end
            OPCODE_LHU: begin ld = 1'b1; size = 2; end
            OPCODE_LW:  ld = 1'b1;
            OPCODE_LWU: ld = 1'b1;
            OPCODE_SB:  begin st = 1'b1; size = 1; end
            OPCODE_SH:  begin st = 1'b1; size = 2; end
            OPCODE_SW:  st = 1'b1;
            default:    ;
        endcase
    endfunction

    function automatic void model_exec(input logic [5:0] op, input logic rd, input logic wr,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic err, output logic [31:0] data);
        logic ld, st, sgn;
        int unsigned size, sh;
        logic [31:0] mask, w;
        op_info(op, ld, st, sgn, size);
        err = 1'b0;
        data = '0;
        if (!rd && !wr) return;
        err = (rd && wr) || (rd && !ld) || (wr && !st) || (addr % size != 0) || (addr / 4 >= DEPTH);
        if (err) return;
        sh = (addr % 4) * 8;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        if (wr) begin
            model_mem[addr / 4] = (model_mem[addr / 4] & ~(mask << sh)) | ((wd & mask) << sh);
        end else begin
            w = (model_mem[addr / 4] >> sh) & mask;
            if (sgn && w[8 * size - 1]) w = w | ~mask;
            data = w;
        end
    endfunction

    task automatic do_req(input logic [5:0] op, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic got_err, output logic [31:0] got_data);
        int n;
        int exp_lat;
        logic seen, m_err;
        logic [31:0] m_data, pre;
        got_err = 1'b0;
        got_data = '0;
        n = 0;
        while (!bus.req_ready_out && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready_out) begin
            check("ready_timeout", {31'b0, bus.req_ready_out}, 32'd1);
            return;
        end
        bus.opcode_in     = op;
        bus.mem_read_in   = rd;
        bus.mem_write_in  = wr;
        bus.address_in    = addr;
        bus.write_data_in = wd;
        bus.req_valid_in  = 1'b1;
        debug_addr        = addr[AW+1:2];
        @(posedge clk);
        pre = model_mem[addr[AW+1:2]];
        model_exec(op, rd, wr, addr, wd, m_err, m_data);
        exp_lat = (!m_err && rd && !wr) ? LAT : 1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.req_valid_in = 1'b0;
                check("debug_pre_value", debug_data, pre);
            end
            seen = bus.resp_valid_out;
            if (!seen) check("ready_low_wait", {31'b0, bus.req_ready_out}, 32'd0);
        end
        check("resp_latency", 32'(n), 32'(exp_lat));
        got_err = bus.error_out;
        got_data = bus.read_data_out;
        check("model_err", {31'b0, got_err}, {31'b0, m_err});
        check("model_data", got_data, m_data);
        @(negedge clk);
        check("resp_one_cycle", {31'b0, bus.resp_valid_out}, 32'd0);
        check("hold_data", bus.read_data_out, m_data);
        check("hold_err", {31'b0, bus.error_out}, {31'b0, m_err});
    endtask

    task automatic wait_clear(input string name);
        int n;
        int resp_seen;
        n = 0;
        resp_seen = 0;
        while (!bus.req_ready_out && n < 1000) begin
            @(negedge clk);
            n++;
            if (bus.resp_valid_out) resp_seen++;
        end
        check(name, 32'(n), 32'(DEPTH));
        check("no_resp_during_clear", 32'(resp_seen), 32'd0);
    endtask

    logic        e;
    logic [31:0] d;
    logic [5:0]  ops [9];

    initial begin
        bus.req_valid_in = 1'b0;
        bus.address_in = '0;
        bus.write_data_in = '0;
        bus.mem_read_in = 1'b0;
        bus.mem_write_in = 1'b0;
        bus.opcode_in = '0;
        debug_addr = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        // Reset state and CLEAR duration.
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, bus.req_ready_out}, 32'd0);
        check("rst_resp", {31'b0, bus.resp_valid_out}, 32'd0);
        check("rst_data", bus.read_data_out, 32'd0);
        check("rst_err", {31'b0, bus.error_out}, 32'd0);
        check("rst_debug", debug_data, 32'd0);
        reset = 1'b1;
        wait_clear("clear_cycles");
        debug_addr = 8'd255;
        @(negedge clk);
        check("debug_word255", debug_data, 32'd0);

        // Directed vectors.
        vecs.push_back('{OPCODE_SW,  1'b0, 1'b1, 32'h10,  32'h80FF7F01, 1'b0, 32'h0});
        vecs.push_back('{OPCODE_LB,  1'b1, 1'b0, 32'h10,  32'h0, 1'b0, 32'h00000001});
        vecs.push_back('{OPCODE_LB,  1'b1, 1'b0, 32'h11,  32'h0, 1'b0, 32'h0000007F});
        vecs.push_back('{OPCODE_LB,  1'b1, 1'b0, 32'h12,  32'h0, 1'b0, 32'hFFFFFFFF});
        vecs.push_back('{OPCODE_LB,  1'b1, 1'b0, 32'h13,  32'h0, 1'b0, 32'hFFFFFF80});
        vecs.push_back('{OPCODE_LBU, 1'b1, 1'b0, 32'h10,  32'h0, 1'b0, 32'h00000001});
        vecs.push_back('{OPCODE_LBU, 1'b1, 1'b0, 32'h11,  32'h0, 1'b0, 32'h0000007F});
        vecs.push_back('{OPCODE_LBU, 1'b1, 1'b0, 32'h12,  32'h0, 1'b0, 32'h000000FF});
        vecs.push_back('{OPCODE_LBU, 1'b1, 1'b0, 32'h13,  32'h0, 1'b0, 32'h00000080});
        vecs.push_back('{OPCODE_SW,  1'b0, 1'b1, 32'h20,  32'h11223344, 1'b0, 32'h0});
        vecs.push_back('{OPCODE_SH,  1'b0, 1'b1, 32'h22,  32'h0000BEEF, 1'b0, 32'h0});
        vecs.push_back('{OPCODE_LW,  1'b1, 1'b0, 32'h20,  32'h0, 1'b0, 32'hBEEF3344});
        vecs.push_back('{OPCODE_LHU, 1'b1, 1'b0, 32'h22,  32'h0, 1'b0, 32'h0000BEEF});
        vecs.push_back('{OPCODE_LH,  1'b1, 1'b0, 32'h22,  32'h0, 1'b0, 32'hFFFFBEEF});
        vecs.push_back('{OPCODE_SW,  1'b0, 1'b1, 32'h21,  32'hFFFFFFFF, 1'b1, 32'h0});
        vecs.push_back('{OPCODE_LW,  1'b1, 1'b0, 32'h20,  32'h0, 1'b0, 32'hBEEF3344});
        vecs.push_back('{OPCODE_LW,  1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0});
        vecs.push_back('{OPCODE_SW,  1'b0, 1'b1, 32'h400, 32'h5, 1'b1, 32'h0});
        vecs.push_back('{OPCODE_LH,  1'b1, 1'b0, 32'h23,  32'h0, 1'b1, 32'h0});
        vecs.push_back('{OPCODE_LW,  1'b1, 1'b1, 32'h20,  32'h0, 1'b1, 32'h0});
        vecs.push_back('{OPCODE_SB,  1'b1, 1'b0, 32'h20,  32'h0, 1'b1, 32'h0});
        vecs.push_back('{OPCODE_LW,  1'b0, 1'b1, 32'h20,  32'h0, 1'b1, 32'h0});
        vecs.push_back('{OPCODE_LW,  1'b0, 1'b0, 32'h20,  32'h0, 1'b0, 32'h0});
        vecs.push_back('{OPCODE_SB,  1'b0, 1'b1, 32'h23,  32'h000000AB, 1'b0, 32'h0});
        vecs.push_back('{OPCODE_LWU, 1'b1, 1'b0, 32'h20,  32'h0, 1'b0, 32'hABEF3344});
        vecs.push_back('{OPCODE_SW,  1'b0, 1'b1, 32'h3FC, 32'h12345678, 1'b0, 32'h0});
        vecs.push_back('{OPCODE_LW,  1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h12345678});
        foreach (vecs[i]) begin
            do_req(vecs[i].op, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, e, d);
            check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
        end

        // Back-to-back word loads; latency and ready-low are checked inside do_req.
        do_req(OPCODE_LW, 1'b1, 1'b0, 32'h10, 32'h0, e, d);
        check("b2b_lw0", d, 32'h80FF7F01);
        do_req(OPCODE_LW, 1'b1, 1'b0, 32'h20, 32'h0, e, d);
        check("b2b_lw1", d, 32'hABEF3344);

        // Randomized traffic against the reference model.
        ops = '{OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU, OPCODE_LW, OPCODE_LWU,
                OPCODE_SB, OPCODE_SH, OPCODE_SW};
        for (int i = 0; i < 250; i++) begin
            logic [5:0]  op;
            logic        rd, wr, ld, st, sgn;
            logic [31:0] addr;
            int unsigned size, sel, k;
            op = ops[$urandom_range(0, 8)];
            op_info(op, ld, st, sgn, size);
            sel = $urandom_range(0, 9);
            if (sel == 0)      addr = $urandom;
            else if (sel == 1) addr = 32'h3F0 + 32'($urandom_range(0, 31));
            else               addr = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(size) - 32'd1);
            k = $urandom_range(0, 15);
            if (k == 0)      begin rd = 1'b1; wr = 1'b1; end
            else if (k == 1) begin rd = 1'b0; wr = 1'b0; end
            else if (k == 2) begin rd = st; wr = ld; end
            else             begin rd = ld; wr = st; end
            do_req(op, rd, wr, addr, $urandom, e, d);
        end

        // Reset one cycle after a load is accepted: no response, memory re-zeroed.
        do_req(OPCODE_SW, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, e, d);
        bus.opcode_in = OPCODE_LW;
        bus.mem_read_in = 1'b1;
        bus.mem_write_in = 1'b0;
        bus.address_in = 32'h40;
        bus.req_valid_in = 1'b1;
        debug_addr = 8'h10;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_in = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_ready", {31'b0, bus.req_ready_out}, 32'd0);
        check("midrst_resp", {31'b0, bus.resp_valid_out}, 32'd0);
        check("midrst_debug", debug_data, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_resp", {31'b0, bus.resp_valid_out}, 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        reset = 1'b1;
        wait_clear("clear_cycles_again");
        @(negedge clk);
        check("debug_after_clear", debug_data, 32'd0);
        do_req(OPCODE_LW, 1'b1, 1'b0, 32'h40, 32'h0, e, d);
        check("load_after_clear", d, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
